music_player_ctrl: RTL and testbench

Parametrised playback controller for the music player: a generalisation of the two-button song control and the fixed 1/1000 beat divider to N songs, previous/next navigation, four repeat modes and three tempos. Sits between the debounced user buttons and codec frame strobe on one side and song_reader/note_player on the other. It drives their play, reset_play, song, sample_ready and beat inputs.

---
 rtl/player_pkg.sv | 34 +++
 rtl/music_player_ctrl_if.sv | 27 ++
 rtl/music_player_ctrl_beat_gen.sv | 46 ++++
 rtl/music_player_ctrl.sv | 161 ++++++++++++++++
 tb/tb_music_player_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/player_pkg.sv
// Shared types and constants for the music player playback controller.
// Imported by music_player_ctrl, its interface and beat_gen.
package player_pkg;

  typedef enum logic [1:0] {
    RST     = 2'b00,
    PAUSED  = 2'b01,
    PLAYING = 2'b10,
    ADV     = 2'b11
  } state_t;

  localparam logic [1:0] RPT_STOP   = 2'b00;
  localparam logic [1:0] RPT_ONE    = 2'b01;
  localparam logic [1:0] RPT_ALL    = 2'b10;
  localparam logic [1:0] RPT_SINGLE = 2'b11;

  localparam logic [1:0] TEMPO_NORMAL = 2'b00;
  localparam logic [1:0] TEMPO_FAST   = 2'b01;
  localparam logic [1:0] TEMPO_SLOW   = 2'b10;

  localparam int unsigned SIM_BEAT_DIV = 64;

  // Frame strobes per beat for a tempo code; 2'b11 is treated as normal.
  function automatic int unsigned tempo_period(input logic [1:0] tempo,
                                               input int unsigned div);
    case (tempo)
      TEMPO_FAST:          return div / 2;
      TEMPO_SLOW:          return div * 2;
      TEMPO_NORMAL, 2'b11: return div;
      default:             return div;
    endcase
  endfunction

endpackage

// File: rtl/music_player_ctrl_if.sv
// Button/event inputs and song_reader/note_player controls of the player.
// slave: the controller side; master: the button and codec-event side.
interface music_player_ctrl_if #(
  parameter int SONG_W = 2
);
  logic              play_pause;
  logic              next;
  logic              prev;
  logic [1:0]        repeat_mode;
  logic [1:0]        tempo;
  logic              song_done;
  logic              play;
  logic              reset_play;
  logic [SONG_W-1:0] song;
  logic              sample_ready;
  logic              beat;

  modport slave (
    input  play_pause, next, prev, repeat_mode, tempo, song_done,
    output play, reset_play, song, sample_ready, beat
  );

  modport master (
    output play_pause, next, prev, repeat_mode, tempo, song_done,
    input  play, reset_play, song, sample_ready, beat
  );
endinterface

// File: rtl/music_player_ctrl_beat_gen.sv
// Tempo-latched beat divider: counts frame strobes while enabled and pulses
// beat on the strobe that completes the period latched at clear or wrap.
module beat_gen
  import player_pkg::*;
#(
  parameter int unsigned DIV = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       tick,
  input  logic [1:0] tempo,
  output logic       beat
);

  localparam int CNT_W = $clog2(2 * DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;
  logic [CNT_W-1:0] last_sel;

  assign last_sel = CNT_W'(tempo_period(tempo, DIV) - 1);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and simulation matches the netlist.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt  <= '0;
      last <= last_sel;
      beat <= 1'b0;
    end else begin
      beat <= 1'b0;
      if (en && tick) begin
        if (cnt == last) begin
          cnt  <= '0;
          last <= last_sel;
          beat <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/music_player_ctrl.sv
// Playback controller: frame synchroniser, play/pause/navigation FSM, beat.
// Optional macro PLAYER_SHUFFLE_EN turns repeat-all into shuffle-all.
module music_player_ctrl
  import player_pkg::*;
#(
  parameter int NUM_SONGS = 4,
  parameter int BEAT_DIV  = 1000,
  parameter int SIM       = 0,
  localparam int SONG_W   = $clog2(NUM_SONGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                NewFrame,
  music_player_ctrl_if.slave  bus
);

  localparam int unsigned DIV_EFF = (SIM != 0) ? SIM_BEAT_DIV : BEAT_DIV;

  state_t            state, state_n;
  logic              resume, resume_n;
  logic [SONG_W-1:0] song, song_n;

  logic nf_meta, nf_sync, nf_prev;
  logic sample_ready_q;
  logic frame_edge;
  logic beat;

  function automatic logic [SONG_W-1:0] song_inc(input logic [SONG_W-1:0] s);
    return (s == SONG_W'(NUM_SONGS - 1)) ? '0 : s + 1'b1;
  endfunction

  function automatic logic [SONG_W-1:0] song_dec(input logic [SONG_W-1:0] s);
    return (s == '0) ? SONG_W'(NUM_SONGS - 1) : s - 1'b1;
  endfunction

  // Two-flop synchroniser plus edge detect on the asynchronous codec strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      nf_meta        <= 1'b0;
      nf_sync        <= 1'b0;
      nf_prev        <= 1'b0;
      sample_ready_q <= 1'b0;
    end else begin
      nf_meta        <= NewFrame;
      nf_sync        <= nf_meta;
      nf_prev        <= nf_sync;
      sample_ready_q <= frame_edge;
    end
  end

  assign frame_edge = nf_sync & ~nf_prev;

`ifdef PLAYER_SHUFFLE_EN
  logic [7:0]        lfsr;
  logic [SONG_W-1:0] shuffle_song;

  // x^8+x^6+x^5+x^4+1, free-running so the pick depends on play timing.
  always_ff @(posedge clk) begin
    if (reset) lfsr <= 8'h01;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  always_comb begin
    shuffle_song = lfsr[SONG_W-1:0];
    if ({1'b0, shuffle_song} >= (SONG_W + 1)'(NUM_SONGS))
      shuffle_song = shuffle_song - SONG_W'(NUM_SONGS);
    if (shuffle_song == song)
      shuffle_song = song_inc(song);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RST;
      resume <= 1'b0;
      song   <= '0;
    end else begin
      state  <= state_n;
      resume <= resume_n;
      song   <= song_n;
    end
  end

  // Song changes on entry to ADV so the new index leads reset_play by a cycle.
  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_n  = state;
    resume_n = resume;
    song_n   = song;
    case (state)
      RST: state_n = resume ? PLAYING : PAUSED;
      PAUSED: begin
        if (bus.next) begin
          state_n  = ADV;
          resume_n = 1'b0;
          song_n   = song_inc(song);
        end else if (bus.prev) begin
          state_n  = ADV;
          resume_n = 1'b0;
          song_n   = song_dec(song);
        end else if (bus.play_pause) begin
          state_n = PLAYING;
        end
      end
      PLAYING: begin
        if (bus.next) begin
          state_n  = ADV;
          resume_n = 1'b1;
          song_n   = song_inc(song);
        end else if (bus.prev) begin
          state_n  = ADV;
          resume_n = 1'b1;
          song_n   = song_dec(song);
        end else if (bus.song_done) begin
          state_n = RST;
          case (bus.repeat_mode)
            RPT_STOP: begin
              resume_n = (song != SONG_W'(NUM_SONGS - 1));
              song_n   = song_inc(song);
            end
            RPT_ONE: resume_n = 1'b1;
            RPT_ALL: begin
              resume_n = 1'b1;
`ifdef PLAYER_SHUFFLE_EN
              song_n   = shuffle_song;
`else
              song_n   = song_inc(song);
`endif
            end
            RPT_SINGLE: resume_n = 1'b0;
            default:    resume_n = 1'b0;
          endcase
        end else if (bus.play_pause) begin
          state_n = PAUSED;
        end
      end
      ADV:     state_n = RST;
      default: state_n = RST;
    endcase
  end

  beat_gen #(
    .DIV (DIV_EFF)
  ) u_beat_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (state == RST),
    .en    (state == PLAYING),
    .tick  (frame_edge),
    .tempo (bus.tempo),
    .beat  (beat)
  );

  assign bus.play         = (state == PLAYING);
  assign bus.reset_play   = (state == RST);
  assign bus.song         = song;
  assign bus.sample_ready = sample_ready_q;
  assign bus.beat         = beat;

endmodule

// File: tb/tb_music_player_ctrl.sv
// Directed self-checking bench for music_player_ctrl (NUM_SONGS=4, SIM=1).
// Compile with PLAYER_SHUFFLE_EN defined to exercise shuffle-all.
module tb_music_player_ctrl;
  import player_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic NewFrame = 1'b0;

  music_player_ctrl_if #(.SONG_W(2)) bus ();

  music_player_ctrl #(
    .NUM_SONGS (4),
    .BEAT_DIV  (1000),
    .SIM       (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .NewFrame (NewFrame),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sr_cnt = 0;
  int beats = 0;
  int last_beat_sr = 0;
  int misalign = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle and tally frame strobes and beats seen since start.
  task automatic cyc();
    @(negedge clk);
    if (bus.sample_ready) sr_cnt++;
    if (bus.beat) begin
      beats++;
      last_beat_sr = sr_cnt;
      if (!bus.sample_ready) misalign++;
    end
  endtask

  task automatic ev(input logic n, input logic p, input logic pp, input logic sd);
    bus.next       = n;
    bus.prev       = p;
    bus.play_pause = pp;
    bus.song_done  = sd;
    cyc();
    bus.next       = 1'b0;
    bus.prev       = 1'b0;
    bus.play_pause = 1'b0;
    bus.song_done  = 1'b0;
  endtask

  task automatic frame();
    NewFrame = 1'b1;
    cyc();
    cyc();
    NewFrame = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic frames_until_beat(input int max_f, output int n);
    int start_sr;
    int b0;
    start_sr = sr_cnt;
    b0 = beats;
    n = -1;
    for (int i = 0; i < max_f && beats == b0; i++) frame();
    if (beats != b0) n = last_beat_sr - start_sr;
  endtask

  int n;
  int b_hold;
  logic [1:0] old_song;

  initial begin
    bus.next = 1'b0;
    bus.prev = 1'b0;
    bus.play_pause = 1'b0;
    bus.song_done = 1'b0;
    bus.repeat_mode = RPT_STOP;
    bus.tempo = TEMPO_NORMAL;

    // Reset for 3 cycles.
    cyc(); cyc(); cyc();
    check("rst_reset_play", 32'(bus.reset_play), 1);
    check("rst_play", 32'(bus.play), 0);
    check("rst_song", 32'(bus.song), 0);
    check("rst_sample_ready", 32'(bus.sample_ready), 0);
    check("rst_beat", 32'(bus.beat), 0);
    reset = 1'b0;
    cyc();
    check("post_rst_reset_play", 32'(bus.reset_play), 0);
    check("post_rst_play", 32'(bus.play), 0);

    ev(0, 0, 1, 0);
    check("pp_play", 32'(bus.play), 1);

    // next while playing: song at +1, reset_play at +2, play at +3.
    ev(1, 0, 0, 0);
    check("nav_song_t1", 32'(bus.song), 1);
    check("nav_play_t1", 32'(bus.play), 0);
    check("nav_rp_t1", 32'(bus.reset_play), 0);
    cyc();
    check("nav_rp_t2", 32'(bus.reset_play), 1);
    cyc();
    check("nav_play_t3", 32'(bus.play), 1);
    check("nav_rp_t3", 32'(bus.reset_play), 0);
    ev(1, 0, 0, 0); cyc(); cyc();
    ev(1, 0, 0, 0); cyc(); cyc();
    check("song3", 32'(bus.song), 3);

    // Wrap from last song while playing.
    ev(1, 0, 0, 0);
    check("wrap_next_song", 32'(bus.song), 0);
    cyc();
    check("wrap_next_rp", 32'(bus.reset_play), 1);
    cyc();
    check("wrap_next_play", 32'(bus.play), 1);

    // prev from song 0 while paused.
    ev(0, 0, 1, 0);
    check("pause_play", 32'(bus.play), 0);
    ev(0, 1, 0, 0); cyc(); cyc();
    check("prev_wrap_song", 32'(bus.song), 3);
    check("prev_wrap_play", 32'(bus.play), 0);

    // song_done on song 3, stop-at-end.
    ev(0, 0, 1, 0);
    bus.repeat_mode = RPT_STOP;
    ev(0, 0, 0, 1);
    check("stop_rp", 32'(bus.reset_play), 1);
    check("stop_song", 32'(bus.song), 0);
    cyc();
    check("stop_play", 32'(bus.play), 0);

    // repeat-one on song 3.
    ev(0, 1, 0, 0); cyc(); cyc();
    ev(0, 0, 1, 0);
    bus.repeat_mode = RPT_ONE;
    ev(0, 0, 0, 1); cyc();
    check("one_song", 32'(bus.song), 3);
    check("one_play", 32'(bus.play), 1);

    // single on song 3.
    bus.repeat_mode = RPT_SINGLE;
    ev(0, 0, 0, 1); cyc();
    check("single_song", 32'(bus.song), 3);
    check("single_play", 32'(bus.play), 0);

    // stop-at-end on a non-last song keeps playing.
    ev(1, 0, 0, 0); cyc(); cyc();
    ev(0, 0, 1, 0);
    bus.repeat_mode = RPT_STOP;
    ev(0, 0, 0, 1); cyc();
    check("stop_mid_song", 32'(bus.song), 1);
    check("stop_mid_play", 32'(bus.play), 1);

    // next+prev+play_pause together: only next acts.
    ev(1, 1, 1, 0); cyc(); cyc();
    check("prio_song", 32'(bus.song), 2);
    check("prio_play", 32'(bus.play), 1);

    // song_done with next in single mode: next wins.
    bus.repeat_mode = RPT_SINGLE;
    ev(1, 0, 0, 1); cyc(); cyc();
    check("done_next_song", 32'(bus.song), 3);
    check("done_next_play", 32'(bus.play), 1);

    // next held into the ADV cycle is dropped there.
    bus.next = 1'b1;
    cyc();
    cyc();
    bus.next = 1'b0;
    cyc();
    check("adv_drop_song", 32'(bus.song), 0);
    check("adv_drop_play", 32'(bus.play), 1);

    // Repeat-all (or shuffle-all) from song 3.
    ev(0, 1, 0, 0); cyc(); cyc();
    bus.repeat_mode = RPT_ALL;
`ifdef PLAYER_SHUFFLE_EN
    for (int i = 0; i < 50; i++) begin
      old_song = bus.song;
      ev(0, 0, 0, 1); cyc();
      check("shuffle_range", 32'(bus.song < 2'd4), 1);
      check("shuffle_differs", 32'(bus.song != old_song), 1);
      check("shuffle_play", 32'(bus.play), 1);
    end
`else
    ev(0, 0, 0, 1); cyc();
    check("all_song", 32'(bus.song), 0);
    check("all_play", 32'(bus.play), 1);
`endif

    // Reset mid-operation from a known song.
    ev(1, 1, 0, 0); cyc(); cyc();
    reset = 1'b1;
    cyc();
    check("midrst_play", 32'(bus.play), 0);
    check("midrst_rp", 32'(bus.reset_play), 1);
    check("midrst_song", 32'(bus.song), 0);
    reset = 1'b0;
    cyc();
    check("midrst_paused", 32'(bus.reset_play | bus.play), 0);

    // sample_ready latency: high on the 3rd edge after NewFrame sampled high.
    NewFrame = 1'b1;
    cyc();
    check("sr_e1", 32'(bus.sample_ready), 0);
    cyc();
    check("sr_e2", 32'(bus.sample_ready), 0);
    NewFrame = 1'b0;
    cyc();
    check("sr_e3", 32'(bus.sample_ready), 1);
    cyc();
    check("sr_e4", 32'(bus.sample_ready), 0);

    // Beat periods and tempo latching.
    bus.tempo = TEMPO_NORMAL;
    ev(0, 0, 1, 0);
    frames_until_beat(80, n);
    check("beat_normal", 32'(n), 64);
    bus.tempo = TEMPO_FAST;
    frames_until_beat(80, n);
    check("beat_fast_midchange", 32'(n), 64);
    frames_until_beat(40, n);
    check("beat_fast", 32'(n), 32);
    bus.tempo = TEMPO_SLOW;
    frames_until_beat(40, n);
    check("beat_slow_midchange", 32'(n), 32);
    frames_until_beat(150, n);
    check("beat_slow", 32'(n), 128);
    bus.tempo = TEMPO_NORMAL;
    frames_until_beat(150, n);
    check("beat_back_normal", 32'(n), 128);

    // Pause holds the count.
    b_hold = beats;
    for (int i = 0; i < 20; i++) frame();
    check("hold_pre_pause", 32'(beats), 32'(b_hold));
    ev(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) frame();
    check("hold_paused", 32'(beats), 32'(b_hold));
    ev(0, 0, 1, 0);
    frames_until_beat(60, n);
    check("hold_resume", 32'(n), 44);

    check("beat_aligned", 32'(misalign), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
